// File: rtl/tlb_assoc.sv
// Fully associative joint TLB: registered lookup port plus CP0 maintenance (TLBP/TLBR/TLBWI/TLBWR).
// Optional macro TLB_MULTIHIT_EN adds a sticky tlb_shutdown output raised on multiple matches.
module tlb_assoc #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int ASID_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              lk_req,
    input  logic [31:0]       lk_va,
    input  logic              lk_store,
    input  logic [ASID_W-1:0] lk_asid,
    output logic              lk_valid,
    output logic [31:0]       lk_pa,
    output logic              lk_refill,
    output logic              lk_invalid,
    output logic              lk_modified,
    input  logic              op_valid,
    input  logic [1:0]        op_code,
    input  logic [IDX_W-1:0]  op_index,
    input  logic [31:0]       op_hi,
    input  logic [31:0]       op_lo0,
    input  logic [31:0]       op_lo1,
    input  logic              wired_we,
    input  logic [IDX_W-1:0]  wired_in,
    output logic              op_done,
    output logic [31:0]       probe_out,
    output logic [31:0]       rd_hi,
    output logic [31:0]       rd_lo0,
    output logic [31:0]       rd_lo1,
    output logic [IDX_W-1:0]  random_out
`ifdef TLB_MULTIHIT_EN
    ,
    output logic              tlb_shutdown
`endif
);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(ENTRIES - 1);

    logic [18:0]        vpn2_q [ENTRIES];
    logic [ASID_W-1:0]  asid_q [ENTRIES];
    logic [19:0]        pfn0_q [ENTRIES];
    logic [19:0]        pfn1_q [ENTRIES];
    logic [ENTRIES-1:0] g_q, v0_q, d0_q, v1_q, d1_q;

    logic              lk_valid_q, lk_refill_q, lk_invalid_q, lk_modified_q;
    logic              lk_refill_d, lk_invalid_d, lk_modified_d;
    logic [31:0]       lk_pa_q, lk_pa_d;
    logic              op_done_q;
    logic [31:0]       probe_q, probe_d, rd_hi_q, rd_hi_d, rd_lo0_q, rd_lo0_d, rd_lo1_q, rd_lo1_d;
    logic [IDX_W-1:0]  random_q, random_d, wired_q, wired_d;

    logic [ENTRIES-1:0] lk_match_s, pr_match_s;
    logic               unmapped_s, lk_hit_s, lk_multi_s, v_sel_s, d_sel_s, wr_en_s, shutdown_d;
    logic [IDX_W-1:0]   lk_idx_s, wr_idx_s;
    logic [19:0]        pfn_sel_s;
    logic               unused_bits_s;

    function automatic logic [IDX_W-1:0] first_idx(input logic [ENTRIES-1:0] m);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) idx = m[i] ? IDX_W'(i) : idx;
        return idx;
    endfunction

    function automatic logic [31:0] pack_lo(input logic [19:0] pfn, input logic d, input logic v,
                                            input logic g);
        return {6'b000000, pfn, 3'b000, d, v, g};
    endfunction

    assign unused_bits_s = ^{op_hi[12:ASID_W], op_lo0[31:26], op_lo0[5:3], op_lo1[31:26], op_lo1[5:3]};

    // Compare every entry against the lookup address and the probe key.
    always_comb begin
        lk_match_s = '0;
        pr_match_s = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            lk_match_s[i] = (vpn2_q[i] == lk_va[31:13]) && (g_q[i] || (asid_q[i] == lk_asid));
            pr_match_s[i] = (vpn2_q[i] == op_hi[31:13]) &&
                            (g_q[i] || (asid_q[i] == op_hi[ASID_W-1:0]));
        end
    end

    assign unmapped_s = (lk_va[31:30] == 2'b10);
    assign lk_hit_s   = |lk_match_s;
    assign lk_multi_s = |(lk_match_s & (lk_match_s - ENTRIES'(1)));
    assign lk_idx_s   = first_idx(lk_match_s);
    assign pfn_sel_s  = lk_va[12] ? pfn1_q[lk_idx_s] : pfn0_q[lk_idx_s];
    assign v_sel_s    = lk_va[12] ? v1_q[lk_idx_s] : v0_q[lk_idx_s];
    assign d_sel_s    = lk_va[12] ? d1_q[lk_idx_s] : d0_q[lk_idx_s];

`ifdef TLB_MULTIHIT_EN
    logic shutdown_q;
    assign shutdown_d   = shutdown_q | (lk_req & ~unmapped_s & lk_multi_s);
    assign tlb_shutdown = shutdown_q;

    // Sticky multi-hit shutdown flag, cleared only by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) shutdown_q <= 1'b0;
        else        shutdown_q <= shutdown_d;
    end
`else
    logic unused_multi_s;
    assign unused_multi_s = lk_multi_s;
    assign shutdown_d     = 1'b0;
`endif

    // Lookup result: fault priority refill > invalid > modified; outputs hold when idle.
    always_comb begin
        lk_pa_d       = lk_pa_q;
        lk_refill_d   = lk_refill_q;
        lk_invalid_d  = lk_invalid_q;
        lk_modified_d = lk_modified_q;
        if (lk_req) begin
            lk_pa_d       = 32'h0000_0000;
            lk_refill_d   = 1'b0;
            lk_invalid_d  = 1'b0;
            lk_modified_d = 1'b0;
            if (shutdown_d)                 lk_refill_d   = 1'b1;
            else if (unmapped_s)            lk_pa_d       = lk_va & 32'h1FFF_FFFF;
            else if (!lk_hit_s)             lk_refill_d   = 1'b1;
            else if (!v_sel_s)              lk_invalid_d  = 1'b1;
            else if (lk_store && !d_sel_s)  lk_modified_d = 1'b1;
            else                            lk_pa_d       = {pfn_sel_s, lk_va[11:0]};
        end else begin
            lk_pa_d = lk_pa_q;
        end
    end

    // Maintenance decode: probe/read results and write target selection.
    always_comb begin
        probe_d  = probe_q;
        rd_hi_d  = rd_hi_q;
        rd_lo0_d = rd_lo0_q;
        rd_lo1_d = rd_lo1_q;
        wr_en_s  = 1'b0;
        wr_idx_s = op_index;
        if (op_valid) begin
            case (op_code)
                2'b00: probe_d = (|pr_match_s) ? 32'(first_idx(pr_match_s)) : 32'h8000_0000;
                2'b01: begin
                    rd_hi_d  = {vpn2_q[op_index], {(13 - ASID_W){1'b0}}, asid_q[op_index]};
                    rd_lo0_d = pack_lo(pfn0_q[op_index], d0_q[op_index], v0_q[op_index], g_q[op_index]);
                    rd_lo1_d = pack_lo(pfn1_q[op_index], d1_q[op_index], v1_q[op_index], g_q[op_index]);
                end
                2'b10: wr_en_s = 1'b1;
                2'b11: begin
                    wr_en_s  = 1'b1;
                    wr_idx_s = random_q;
                end
                default: wr_en_s = 1'b0;
            endcase
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Random walks down from ENTRIES-1 to Wired and wraps; loading Wired restarts it.
    always_comb begin
        wired_d  = wired_q;
        random_d = random_q;
        if (wired_we) begin
            wired_d  = (32'(wired_in) >= 32'(ENTRIES)) ? IDX_MAX : wired_in;
            random_d = IDX_MAX;
        end else if (random_q == wired_q) begin
            random_d = IDX_MAX;
        end else begin
            random_d = random_q - IDX_W'(1);
        end
    end

    // Entry storage; reset values sit in unmapped space so they never match a lookup.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                vpn2_q[i] <= {2'b10, 17'(i)};
                asid_q[i] <= '0;
                pfn0_q[i] <= 20'h0_0000;
                pfn1_q[i] <= 20'h0_0000;
            end
            g_q  <= '0;
            v0_q <= '0;
            d0_q <= '0;
            v1_q <= '0;
            d1_q <= '0;
        end else if (wr_en_s) begin
            vpn2_q[wr_idx_s] <= op_hi[31:13];
            asid_q[wr_idx_s] <= op_hi[ASID_W-1:0];
            pfn0_q[wr_idx_s] <= op_lo0[25:6];
            pfn1_q[wr_idx_s] <= op_lo1[25:6];
            g_q[wr_idx_s]    <= op_lo0[0] & op_lo1[0];
            v0_q[wr_idx_s]   <= op_lo0[1];
            d0_q[wr_idx_s]   <= op_lo0[2];
            v1_q[wr_idx_s]   <= op_lo1[1];
            d1_q[wr_idx_s]   <= op_lo1[2];
        end
    end

    // Registered outputs and Random/Wired counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lk_valid_q    <= 1'b0;
            lk_pa_q       <= 32'h0000_0000;
            lk_refill_q   <= 1'b0;
            lk_invalid_q  <= 1'b0;
            lk_modified_q <= 1'b0;
            op_done_q     <= 1'b0;
            probe_q       <= 32'h8000_0000;
            rd_hi_q       <= 32'h0000_0000;
            rd_lo0_q      <= 32'h0000_0000;
            rd_lo1_q      <= 32'h0000_0000;
            random_q      <= IDX_MAX;
            wired_q       <= '0;
        end else begin
            lk_valid_q    <= lk_req;
            lk_pa_q       <= lk_pa_d;
            lk_refill_q   <= lk_refill_d;
            lk_invalid_q  <= lk_invalid_d;
            lk_modified_q <= lk_modified_d;
            op_done_q     <= op_valid;
            probe_q       <= probe_d;
            rd_hi_q       <= rd_hi_d;
            rd_lo0_q      <= rd_lo0_d;
            rd_lo1_q      <= rd_lo1_d;
            random_q      <= random_d;
            wired_q       <= wired_d;
        end
    end

    assign lk_valid    = lk_valid_q;
    assign lk_pa       = lk_pa_q;
    assign lk_refill   = lk_refill_q;
    assign lk_invalid  = lk_invalid_q;
    assign lk_modified = lk_modified_q;
    assign op_done     = op_done_q;
    assign probe_out   = probe_q;
    assign rd_hi       = rd_hi_q;
    assign rd_lo0      = rd_lo0_q;
    assign rd_lo1      = rd_lo1_q;
    assign random_out  = random_q;

endmodule
